// File: rtl/t07_arb_pkg.sv
// t07_arb_pkg: shared encodings and constants for the MMIO arbiter
package t07_arb_pkg;
  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_WRITE = 2'b01;
  localparam logic [1:0] RWI_READ  = 2'b10;
  localparam logic [1:0] RWI_FETCH = 2'b11;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/t07_arb_pick.sv
// t07_arb_pick: fixed-priority winner select with starvation override for requester 1
module t07_arb_pick
  import t07_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int SW = 3
) (
  input  logic [1:0]    vld_i,
  input  logic [SW-1:0] starve_cnt_i,
  output logic          win_o,
  output logic          win_vld_o
);
  assign win_vld_o = |vld_i;
  assign win_o = vld_i[1] & (~vld_i[0] | (starve_cnt_i == SW'(STARVE_LIMIT)));
endmodule

// File: rtl/t07_mmio_arbiter.sv
// t07_mmio_arbiter: serialises two requesters onto one MMIO bus, completing on busy fall
module t07_mmio_arbiter
  import t07_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [1:0][1:0]  req_rwi_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_wdata_i,
  output logic [1:0][31:0] req_rdata_o,
  output logic [1:0]       req_busy_o,
  output logic [1:0]       req_done_o,
  output logic [1:0]       mem_rwi_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_busy_i,
  output logic             gnt_o,
  output logic             err_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  arb_state_t state_q, state_d;
  logic gnt_q, gnt_d, err_q, err_d, prev_busy_q, win, win_vld, fall, expire;
  logic [1:0] req_vld, op_q, op_d, mem_rwi_q, mem_rwi_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  assign req_vld = {req_rwi_i[1] != RWI_IDLE, req_rwi_i[0] != RWI_IDLE};
  assign fall = prev_busy_q & ~mem_busy_i;
  assign expire = tmo_q == TW'(TIMEOUT);
  t07_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_pick (
    .vld_i(req_vld),
    .starve_cnt_i(starve_q),
    .win_o(win),
    .win_vld_o(win_vld)
  );
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    err_d = err_q;
    op_d = op_q;
    mem_rwi_d = mem_rwi_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    starve_d = starve_q;
    tmo_d = tmo_q;
    case (state_q)
      IDLE: if (win_vld) begin
        gnt_d = win;
        op_d = req_rwi_i[win];
        mem_rwi_d = req_rwi_i[win];
        mem_addr_d = req_addr_i[win];
        mem_wdata_d = req_wdata_i[win];
        tmo_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d = tmo_q + TW'(1);
        if (expire) begin
          err_d = 1'b1;
          mem_rwi_d = RWI_IDLE;
          rdata_d[gnt_q] = ABORT_DATA;
          state_d = DONE;
        end else if (mem_busy_i) begin
          mem_rwi_d = RWI_IDLE;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // a fall landing on the expiry cycle still counts as a clean completion
        if (fall) begin
          if (op_q == RWI_READ || op_q == RWI_FETCH) rdata_d[gnt_q] = mem_rdata_i;
          state_d = DONE;
        end else if (expire) begin
          err_d = 1'b1;
          rdata_d[gnt_q] = ABORT_DATA;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        starve_d = (gnt_q || !req_vld[1]) ? '0 :
                   (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      err_q <= 1'b0;
      op_q <= RWI_IDLE;
      mem_rwi_q <= RWI_IDLE;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      starve_q <= '0;
      tmo_q <= '0;
      prev_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
      op_q <= op_d;
      mem_rwi_q <= mem_rwi_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      starve_q <= starve_d;
      tmo_q <= tmo_d;
      prev_busy_q <= mem_busy_i;
    end
  end
  assign req_done_o = {(state_q == DONE) && gnt_q, (state_q == DONE) && !gnt_q};
  assign req_busy_o = req_vld & ~req_done_o;
  assign req_rdata_o = rdata_q;
  assign mem_rwi_o = mem_rwi_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign gnt_o = gnt_q;
  assign err_o = err_q;
endmodule

// File: doc/t07_mmio_arbiter.md
Name: t07_mmio_arbiter

Overview:
- Two-requester arbiter for the single external MMIO bus.
- Requester 0 is the CPU memory handler (fetch, load and store traffic). Requester 1 is a secondary master (display/SPI DMA or loader).
- Serialises transactions onto one downstream port and completes each on the downstream busy falling edge.
- Returns read data and a one-cycle done pulse to the owning requester. Fixed priority to requester 0, with a starvation guard and a watchdog timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive requester-0 grants made while requester 1 is waiting, after which requester 1 is forced next.
- TIMEOUT, 255: maximum cycles spent in ISSUE+WAIT before the transaction is aborted.

Ports:
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  asynchronous, active-low reset.
- req_rwi  in  2x2  per-requester op: 00 idle, 01 write, 10 read, 11 fetch (read).
- req_addr  in  2x32  per-requester address.
- req_wdata  in  2x32  per-requester write data.
- req_rdata  out  2x32  per-requester registered read data.
- req_busy  out  2  per-requester busy: (req_rwi[i]!=00) & ~req_done[i].
- req_done  out  2  one-cycle completion pulse, owner only.
- mem_rwi  out  2  downstream op, same encoding as req_rwi.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data.
- mem_busy  in  1  downstream busy.
- gnt  out  1  current/last owner index.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async): state=IDLE; mem_rwi=00; mem_addr=0; mem_wdata=0; req_rdata both 0; req_done=0; gnt=0; err=0; starve_cnt=0; tmo_cnt=0; prev_busy=0.
- prev_busy is a registered copy of mem_busy. fall = prev_busy & ~mem_busy.
- IDLE:
  - Pick a winner among requesters with req_rwi!=00.
  - Only one request: that requester wins.
  - Both requesting: requester 1 wins if starve_cnt==STARVE_LIMIT, else requester 0.
  - Latch gnt, addr, wdata and op into mem_* registers. Clear tmo_cnt. Go to ISSUE.
  - No request: hold mem_rwi=00.
- ISSUE:
  - Drive mem_rwi=latched op. Stay until mem_busy==1, then mem_rwi=00 and go to WAIT.
  - Downstream must assert busy within TIMEOUT cycles.
- WAIT:
  - mem_rwi=00. Wait for fall.
  - If op is read or fetch: req_rdata[gnt] <= mem_rdata on the fall cycle.
  - Go to DONE.
- DONE:
  - req_done[gnt]=1 for exactly this cycle. Go to IDLE.
  - Starvation counter update:
    - gnt==0 and req_rwi[1]!=00: starve_cnt++, saturating at STARVE_LIMIT.
    - gnt==1: starve_cnt cleared.
    - req_rwi[1]==00: starve_cnt cleared.
- Latency: minimum 4 cycles from request to done (IDLE→ISSUE→WAIT→DONE), assuming mem_busy rises 1 cycle after issue and falls 1 cycle later.
- Timeout:
  - tmo_cnt increments every cycle in ISSUE and WAIT.
  - At tmo_cnt==TIMEOUT: err<=1 (sticky until reset), mem_rwi=00, req_rdata[gnt]<=32'hDEADBEEF, go to DONE.
- Request hold rules:
  - A requester holds req_rwi, req_addr and req_wdata stable until its req_done.
  - Changes after the IDLE latch are ignored.
  - A request still held in the cycle after done is treated as a new transaction.
- Simultaneous events:
  - A fall in the same cycle as the timeout expiry counts as normal completion; err stays 0.
  - A request that rises during DONE is arbitrated in the next IDLE.
- Write to a non-owner: req_rdata of the non-owner is never modified.
- Reset mid-transaction: everything returns to the reset values immediately. mem_rwi drops to 00 asynchronously, with no done pulse.

Decomposition:
- Package t07_arb_pkg holds:
  - rwi encoding localparams (RWI_IDLE, RWI_WRITE, RWI_READ, RWI_FETCH).
  - arb_state_t enum: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
  - The DEADBEEF abort constant.
- One sub-module: t07_arb_pick. Purely combinational winner selection from the two request-valid bits, starve_cnt and STARVE_LIMIT. Outputs winner index and valid.

Test Plan:
- Single read: req0 read addr 0x100, mem_busy high 1 cycle after issue, mem_rdata=0xCAFEF00D on fall → req_rdata[0]=0xCAFEF00D, req_done[0] pulses once, 4 cycles total.
- Contention: both request continuously → grants 0,0,0,0,1,0,0,0,0,1 (STARVE_LIMIT=4); starve_cnt resets after each requester-1 grant.
- Write: req1 write addr 0x2000 data 0x12345678 → mem_rwi=01, mem_addr=0x2000, mem_wdata=0x12345678 in ISSUE; req_rdata[1] unchanged.
- Timeout: mem_busy never asserts → after 255 cycles err=1, req_rdata[gnt]=0xDEADBEEF, req_done pulses; next transaction proceeds normally with err still 1.
- Reset mid-WAIT: nrst low while mem_busy=1 → mem_rwi=00, state IDLE, no req_done; after release, a fresh req0 fetch completes normally.
- Fall coincident with timeout expiry → normal completion with mem_rdata captured, err=0.
